tinyqv_mem_arbiter: RTL and testbench

Two-port arbiter in front of the `tinyqv_mem_ctrl` data port. It shares the single QSPI data transaction path between the CPU data port (requester A) and a secondary bus master such as DMA or debug (requester B). Transactions are serialised: one granted requester at a time, held until the memory controller signals completion. Fixed priority goes to A, with a starvation limit that guarantees B forward progress.

---
 rtl/tinyqv_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_tinyqv_mem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tinyqv_mem_arbiter.sv
// Purpose: two-port arbiter sharing the tinyqv_mem_ctrl data port between requester A (CPU)
//          and requester B (DMA/debug). A has fixed priority, bounded by a starvation limit for B.
// Ports:   clk_i/rst_i (sync active-high); a_*/b_* requester buses with a_ready_o/b_ready_o;
//          rdata_o shared read data; mem_* registered request to mem_ctrl, mem_ready_i/mem_rdata_i back.
// Latency: grant registers mem_* one cycle after a request is seen in IDLE; ready and rdata are
//          combinational from mem_ready_i; one forced idle cycle follows every completion.
module tinyqv_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [24:0] a_addr_i,
    input  logic [1:0]  a_write_n_i,
    input  logic [1:0]  a_read_n_i,
    input  logic [31:0] a_wdata_i,
    output logic        a_ready_o,

    input  logic [24:0] b_addr_i,
    input  logic [1:0]  b_write_n_i,
    input  logic [1:0]  b_read_n_i,
    input  logic [31:0] b_wdata_i,
    output logic        b_ready_o,

    output logic [31:0] rdata_o,

    output logic [24:0] mem_addr_o,
    output logic [1:0]  mem_write_n_o,
    output logic [1:0]  mem_read_n_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [24:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  mem_read_n_q, mem_read_n_d;
    logic [1:0]  mem_write_n_q, mem_write_n_d;

    logic a_pend, b_pend;
    logic grant_a, grant_b;

    assign a_pend = (a_read_n_i != 2'b11) || (a_write_n_i != 2'b11);
    assign b_pend = (b_read_n_i != 2'b11) || (b_write_n_i != 2'b11);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_read_n_d  = mem_read_n_q;
        mem_write_n_d = mem_write_n_q;
        grant_a       = 1'b0;
        grant_b       = 1'b0;

        case (state_q)
            IDLE: begin
                if (a_pend && b_pend) begin
                    if (wait_cnt_q >= LIMIT) grant_b = 1'b1;
                    else                     grant_a = 1'b1;
                end else if (a_pend) begin
                    grant_a = 1'b1;
                end else if (b_pend) begin
                    grant_b = 1'b1;
                end
            end
            BUSY_A, BUSY_B: begin
                // Completion drops the strobes on the same edge so mem_ctrl sees an idle cycle.
                if (mem_ready_i) begin
                    state_d       = IDLE;
                    mem_read_n_d  = 2'b11;
                    mem_write_n_d = 2'b11;
                end
            end
            default: state_d = IDLE;
        endcase

        // A simultaneous read and write request is served as the read only.
        if (grant_a) begin
            state_d       = BUSY_A;
            mem_addr_d    = a_addr_i;
            mem_wdata_d   = a_wdata_i;
            mem_read_n_d  = a_read_n_i;
            mem_write_n_d = (a_read_n_i != 2'b11) ? 2'b11 : a_write_n_i;
        end else if (grant_b) begin
            state_d       = BUSY_B;
            mem_addr_d    = b_addr_i;
            mem_wdata_d   = b_wdata_i;
            mem_read_n_d  = b_read_n_i;
            mem_write_n_d = (b_read_n_i != 2'b11) ? 2'b11 : b_write_n_i;
        end

        // B wait counter: counts A grants that overtook a pending B.
        if (grant_b) begin
            wait_cnt_d = 4'd0;
        end else if (grant_a && b_pend) begin
            if (wait_cnt_q != 4'hF) wait_cnt_d = wait_cnt_q + 4'd1;
        end else if ((state_q == IDLE) && !b_pend) begin
            wait_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            wait_cnt_q    <= 4'd0;
            mem_addr_q    <= 25'd0;
            mem_wdata_q   <= 32'd0;
            mem_read_n_q  <= 2'b11;
            mem_write_n_q <= 2'b11;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_read_n_q  <= mem_read_n_d;
            mem_write_n_q <= mem_write_n_d;
        end
    end

    assign a_ready_o     = mem_ready_i && (state_q == BUSY_A);
    assign b_ready_o     = mem_ready_i && (state_q == BUSY_B);
    assign rdata_o       = mem_rdata_i;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign mem_read_n_o  = mem_read_n_q;
    assign mem_write_n_o = mem_write_n_q;

endmodule

// File: tb/tb_tinyqv_mem_arbiter.sv
// Directed bench for tinyqv_mem_arbiter: three instances (STARVE_LIMIT 4, 2, 0) share one
// set of stimulus; each step checks the relevant instance against hand-computed values.
module tb_tinyqv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [24:0] a_addr = '0, b_addr = '0;
    logic [1:0]  a_write_n = 2'b11, a_read_n = 2'b11;
    logic [1:0]  b_write_n = 2'b11, b_read_n = 2'b11;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        d4_a_ready, d4_b_ready, d2_a_ready, d2_b_ready, d0_a_ready, d0_b_ready;
    logic [31:0] d4_rdata, d2_rdata, d0_rdata;
    logic [24:0] d4_mem_addr, d2_mem_addr, d0_mem_addr;
    logic [1:0]  d4_mem_write_n, d2_mem_write_n, d0_mem_write_n;
    logic [1:0]  d4_mem_read_n, d2_mem_read_n, d0_mem_read_n;
    logic [31:0] d4_mem_wdata, d2_mem_wdata, d0_mem_wdata;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tinyqv_mem_arbiter d4 (
        .clk_i(clk), .rst_i(rst),
        .a_addr_i(a_addr), .a_write_n_i(a_write_n), .a_read_n_i(a_read_n), .a_wdata_i(a_wdata),
        .a_ready_o(d4_a_ready),
        .b_addr_i(b_addr), .b_write_n_i(b_write_n), .b_read_n_i(b_read_n), .b_wdata_i(b_wdata),
        .b_ready_o(d4_b_ready),
        .rdata_o(d4_rdata),
        .mem_addr_o(d4_mem_addr), .mem_write_n_o(d4_mem_write_n), .mem_read_n_o(d4_mem_read_n),
        .mem_wdata_o(d4_mem_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
    );

    tinyqv_mem_arbiter #(.STARVE_LIMIT(2)) d2 (
        .clk_i(clk), .rst_i(rst),
        .a_addr_i(a_addr), .a_write_n_i(a_write_n), .a_read_n_i(a_read_n), .a_wdata_i(a_wdata),
        .a_ready_o(d2_a_ready),
        .b_addr_i(b_addr), .b_write_n_i(b_write_n), .b_read_n_i(b_read_n), .b_wdata_i(b_wdata),
        .b_ready_o(d2_b_ready),
        .rdata_o(d2_rdata),
        .mem_addr_o(d2_mem_addr), .mem_write_n_o(d2_mem_write_n), .mem_read_n_o(d2_mem_read_n),
        .mem_wdata_o(d2_mem_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
    );

    tinyqv_mem_arbiter #(.STARVE_LIMIT(0)) d0 (
        .clk_i(clk), .rst_i(rst),
        .a_addr_i(a_addr), .a_write_n_i(a_write_n), .a_read_n_i(a_read_n), .a_wdata_i(a_wdata),
        .a_ready_o(d0_a_ready),
        .b_addr_i(b_addr), .b_write_n_i(b_write_n), .b_read_n_i(b_read_n), .b_wdata_i(b_wdata),
        .b_ready_o(d0_b_ready),
        .rdata_o(d0_rdata),
        .mem_addr_o(d0_mem_addr), .mem_write_n_o(d0_mem_write_n), .mem_read_n_o(d0_mem_read_n),
        .mem_wdata_o(d0_mem_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Grant order for STARVE_LIMIT=2 with both requesters always pending: 1 = A, 0 = B.
    logic [5:0] exp_is_a;
    logic [3:0] exp_wait [6];

    initial begin
        exp_is_a = 6'b011011;
        exp_wait[0] = 4'd1; exp_wait[1] = 4'd2; exp_wait[2] = 4'd0;
        exp_wait[3] = 4'd1; exp_wait[4] = 4'd2; exp_wait[5] = 4'd0;

        // Reset state
        do_reset();
        chk("rst_read_n",  {30'd0, d4_mem_read_n}, 32'h3);
        chk("rst_write_n", {30'd0, d4_mem_write_n}, 32'h3);
        chk("rst_addr",    {7'd0, d4_mem_addr}, 32'h0);
        chk("rst_wdata",   d4_mem_wdata, 32'h0);
        chk("rst_ready",   {30'd0, d4_a_ready, d4_b_ready}, 32'h0);
        chk("rst_wait",    {28'd0, d4.wait_cnt_q}, 32'h0);

        // A 32-bit read of 0x000100
        a_read_n = 2'b10; a_addr = 25'h000100;
        tick();
        chk("a_rd_read_n", {30'd0, d4_mem_read_n}, 32'h2);
        chk("a_rd_addr",   {7'd0, d4_mem_addr}, 32'h100);
        chk("a_rd_write_n", {30'd0, d4_mem_write_n}, 32'h3);
        chk("a_rd_no_ready", {31'd0, d4_a_ready}, 32'h0);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("a_rd_a_ready", {31'd0, d4_a_ready}, 32'h1);
        chk("a_rd_b_ready", {31'd0, d4_b_ready}, 32'h0);
        chk("a_rd_rdata",   d4_rdata, 32'hDEADBEEF);
        tick();
        mem_ready = 1'b0; a_read_n = 2'b11;
        #1;
        chk("a_rd_done_read_n", {30'd0, d4_mem_read_n}, 32'h3);
        chk("a_rd_done_ready",  {31'd0, d4_a_ready}, 32'h0);
        tick();
        chk("a_rd_stay_idle", {30'd0, d4.state_q}, 32'h0);

        // mem_ready while IDLE is ignored
        mem_ready = 1'b1;
        #1;
        chk("idle_ready_ignored", {30'd0, d4_a_ready, d4_b_ready}, 32'h0);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("idle_ready_state", {30'd0, d4.state_q}, 32'h0);

        // B 8-bit write of 0x5A to 0x1000010
        b_write_n = 2'b00; b_addr = 25'h1000010; b_wdata = 32'h5A;
        tick();
        chk("b_wr_state",   {30'd0, d4.state_q}, 32'h2);
        chk("b_wr_write_n", {30'd0, d4_mem_write_n}, 32'h0);
        chk("b_wr_read_n",  {30'd0, d4_mem_read_n}, 32'h3);
        chk("b_wr_wdata",   d4_mem_wdata, 32'h0000005A);
        chk("b_wr_addr",    {7'd0, d4_mem_addr}, 32'h1000010);
        mem_ready = 1'b1;
        #1;
        chk("b_wr_b_ready", {31'd0, d4_b_ready}, 32'h1);
        chk("b_wr_a_ready", {31'd0, d4_a_ready}, 32'h0);
        tick();
        mem_ready = 1'b0; b_write_n = 2'b11;
        #1;
        chk("b_wr_done_write_n", {30'd0, d4_mem_write_n}, 32'h3);
        tick();

        // Read and write both requested: read wins, write strobe latched as none
        a_read_n = 2'b01; a_write_n = 2'b00; a_addr = 25'h000044;
        tick();
        chk("rw_read_n",  {30'd0, d4_mem_read_n}, 32'h1);
        chk("rw_write_n", {30'd0, d4_mem_write_n}, 32'h3);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; a_read_n = 2'b11; a_write_n = 2'b11;
        tick();

        // Requester changes after grant do not reach mem_*
        a_write_n = 2'b10; a_addr = 25'h000200; a_wdata = 32'h12345678;
        tick();
        a_addr = 25'h1FFFFFF; a_wdata = 32'hFFFFFFFF;
        tick();
        chk("hold_addr",  {7'd0, d4_mem_addr}, 32'h200);
        chk("hold_wdata", d4_mem_wdata, 32'h12345678);
        chk("hold_write_n", {30'd0, d4_mem_write_n}, 32'h2);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; a_write_n = 2'b11;
        tick();

        // Starvation: both requesters pending throughout
        do_reset();
        a_read_n = 2'b10; a_addr = 25'h000010;
        b_read_n = 2'b10; b_addr = 25'h000020;
        #1;
        chk("starve_wait_init", {28'd0, d2.wait_cnt_q}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("starve_addr_%0d", i), {7'd0, d2_mem_addr},
                exp_is_a[i] ? 32'h10 : 32'h20);
            if (i == 0) begin
                chk("lim0_first_b", {7'd0, d0_mem_addr}, 32'h20);
                chk("lim4_first_a", {7'd0, d4_mem_addr}, 32'h10);
            end
            mem_ready = 1'b1;
            #1;
            chk($sformatf("starve_ready_%0d", i), {30'd0, d2_a_ready, d2_b_ready},
                exp_is_a[i] ? 32'h2 : 32'h1);
            tick();
            mem_ready = 1'b0;
            #1;
            chk($sformatf("starve_wait_%0d", i), {28'd0, d2.wait_cnt_q}, {28'd0, exp_wait[i]});
        end
        a_read_n = 2'b11; b_read_n = 2'b11;

        // Reset three cycles into BUSY_A
        do_reset();
        a_read_n = 2'b10; a_addr = 25'h000300;
        b_read_n = 2'b10; b_addr = 25'h000400;
        tick();
        chk("abort_busy_a", {30'd0, d4.state_q}, 32'h1);
        chk("abort_wait_pre", {28'd0, d4.wait_cnt_q}, 32'h1);
        tick();
        tick();
        rst = 1'b1; a_read_n = 2'b11; b_read_n = 2'b11;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_state",  {30'd0, d4.state_q}, 32'h0);
        chk("abort_read_n", {30'd0, d4_mem_read_n}, 32'h3);
        chk("abort_wait",   {28'd0, d4.wait_cnt_q}, 32'h0);
        mem_ready = 1'b1;
        #1;
        chk("abort_no_ready", {30'd0, d4_a_ready, d4_b_ready}, 32'h0);
        tick();
        mem_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
